// File: rtl/fc_argmax_collector.sv
// Snoops FC2 score writes on the SRAM F port for two image sets, then runs a
// sequential signed argmax per set and offers the winners on a valid/ready port.
module fc_argmax_collector #(
    parameter int NUM_CLASS = 10,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 2,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              srstn,
    input  logic              conv_start,
    input  logic              fc2_done,
    input  logic              sram_write_enable_f,
    input  logic [3:0]        sram_bytemask_f,
    input  logic [ADDR_W-1:0] sram_waddr_f,
    input  logic [DATA_W-1:0] sram_wdata_f,
    input  logic [DATA_W-1:0] sram_wdata_f_1,
    output logic              busy,
    output logic              result_valid,
    input  logic              result_ready,
    output logic [IDX_W-1:0]  class_0,
    output logic [IDX_W-1:0]  class_1,
    output logic [DATA_W-1:0] score_0,
    output logic [DATA_W-1:0] score_1
);

    localparam int                       CAP_W     = ADDR_W + 2;
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_CLASS - 1);
    localparam logic signed [DATA_W-1:0] MIN_SCORE = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {CAPT, SCAN, VALID} state_t;

    state_t state_q, state_d;
    logic   fc2_done_q;
    logic   start_scan;
    logic   scan_last;

    logic signed [DATA_W-1:0] score_s0 [NUM_CLASS];
    logic signed [DATA_W-1:0] score_s1 [NUM_CLASS];
    logic [NUM_CLASS-1:0]     wr_hit;

    logic [IDX_W-1:0]         idx_q;
    logic signed [DATA_W-1:0] max_0_q, max_1_q;
    logic [IDX_W-1:0]         cls_0_q, cls_1_q;
    logic signed [DATA_W-1:0] cur_0, cur_1, cand_0, cand_1;
    logic [IDX_W-1:0]         cand_cls_0, cand_cls_1;
    logic                     take_0, take_1;

    assign start_scan   = fc2_done & ~fc2_done_q;
    assign scan_last    = (state_q == SCAN) && (idx_q == LAST_IDX);
    assign busy         = (state_q != CAPT);
    assign result_valid = (state_q == VALID);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            state_q    <= CAPT;
            fc2_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fc2_done_q <= fc2_done;
        end
    end

    // NOTE: next-state is defaulted to the current state first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CAPT:    if (start_scan)   state_d = SCAN;
            SCAN:    if (scan_last)    state_d = VALID;
            VALID:   if (result_ready) state_d = CAPT;
            default:                   state_d = CAPT;
        endcase
        if (conv_start) state_d = CAPT;
    end

    // Every low mask bit maps the same byte onto index waddr*4+k; out-of-range indices match nothing.
    always_comb begin
        wr_hit = '0;
        for (int j = 0; j < NUM_CLASS; j++) begin
            for (int k = 0; k < 4; k++) begin
                if (!sram_write_enable_f && !sram_bytemask_f[k] &&
                    ({sram_waddr_f, 2'(k)} == CAP_W'(j)))
                    wr_hit[j] = 1'b1;
            end
        end
    end

    // NOTE: the shadow array is reset because unwritten scores must read as the most negative value.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            for (int j = 0; j < NUM_CLASS; j++) begin
                score_s0[j] <= MIN_SCORE;
                score_s1[j] <= MIN_SCORE;
            end
        end else if (conv_start) begin
            for (int j = 0; j < NUM_CLASS; j++) begin
                score_s0[j] <= MIN_SCORE;
                score_s1[j] <= MIN_SCORE;
            end
        end else if (state_q == CAPT) begin
            for (int j = 0; j < NUM_CLASS; j++) begin
                if (wr_hit[j]) begin
                    score_s0[j] <= sram_wdata_f;
                    score_s1[j] <= sram_wdata_f_1;
                end
            end
        end
    end

    // Index 0 seeds the running max; strict greater-than keeps the lower index on ties.
    always_comb begin
        cur_0      = score_s0[idx_q];
        cur_1      = score_s1[idx_q];
        take_0     = (idx_q == '0) || (cur_0 > max_0_q);
        take_1     = (idx_q == '0) || (cur_1 > max_1_q);
        cand_0     = take_0 ? cur_0 : max_0_q;
        cand_1     = take_1 ? cur_1 : max_1_q;
        cand_cls_0 = take_0 ? idx_q : cls_0_q;
        cand_cls_1 = take_1 ? idx_q : cls_1_q;
    end

    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            idx_q   <= '0;
            max_0_q <= '0;
            max_1_q <= '0;
            cls_0_q <= '0;
            cls_1_q <= '0;
        end else if ((state_q == SCAN) && !conv_start) begin
            idx_q   <= idx_q + 1'b1;
            max_0_q <= cand_0;
            max_1_q <= cand_1;
            cls_0_q <= cand_cls_0;
            cls_1_q <= cand_cls_1;
        end else begin
            idx_q   <= '0;
        end
    end

    // Result registers load once, on the final compare, and otherwise hold their last value.
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            class_0 <= '0;
            class_1 <= '0;
            score_0 <= '0;
            score_1 <= '0;
        end else if (scan_last && !conv_start) begin
            class_0 <= cand_cls_0;
            class_1 <= cand_cls_1;
            score_0 <= cand_0;
            score_1 <= cand_1;
        end
    end

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Directed bench for fc_argmax_collector: capture, argmax, ties, masking,
// handshake hold, conv_start abort and asynchronous reset.
module tb_fc_argmax_collector;

    typedef logic signed [7:0] vec_t [10];

    logic       clk = 1'b0;
    logic       srstn;
    logic       conv_start;
    logic       fc2_done;
    logic       sram_write_enable_f;
    logic [3:0] sram_bytemask_f;
    logic [1:0] sram_waddr_f;
    logic [7:0] sram_wdata_f;
    logic [7:0] sram_wdata_f_1;
    logic       busy;
    logic       result_valid;
    logic       result_ready;
    logic [3:0] class_0, class_1;
    logic [7:0] score_0, score_1;

    int checks = 0;
    int errors = 0;

    fc_argmax_collector dut (
        .clk                 (clk),
        .srstn               (srstn),
        .conv_start          (conv_start),
        .fc2_done            (fc2_done),
        .sram_write_enable_f (sram_write_enable_f),
        .sram_bytemask_f     (sram_bytemask_f),
        .sram_waddr_f        (sram_waddr_f),
        .sram_wdata_f        (sram_wdata_f),
        .sram_wdata_f_1      (sram_wdata_f_1),
        .busy                (busy),
        .result_valid        (result_valid),
        .result_ready        (result_ready),
        .class_0             (class_0),
        .class_1             (class_1),
        .score_0             (score_0),
        .score_1             (score_1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [1:0] addr, input logic [3:0] mask,
                              input logic [7:0] d0, input logic [7:0] d1);
        sram_write_enable_f = 1'b0;
        sram_waddr_f        = addr;
        sram_bytemask_f     = mask;
        sram_wdata_f        = d0;
        sram_wdata_f_1      = d1;
        tick();
        sram_write_enable_f = 1'b1;
        sram_bytemask_f     = 4'hF;
    endtask

    task automatic load_sets(input vec_t a0, input vec_t a1);
        for (int i = 0; i < 10; i++) begin
            logic [3:0] m;
            m = 4'hF;
            m[i % 4] = 1'b0;
            write_word(2'(i / 4), m, a0[i], a1[i]);
        end
    endtask

    task automatic clear_scores();
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
    endtask

    // Pulses fc2_done and waits (bounded) for result_valid; latency must be NUM_CLASS+1.
    task automatic run_scan(input string tag);
        int n;
        fc2_done = 1'b1;
        tick();
        fc2_done = 1'b0;
        check({tag, "_busy_scan"}, int'(busy), 1);
        n = 0;
        while (!result_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 10);
    endtask

    task automatic check_result(input string tag, input int c0, input int s0,
                                input int c1, input int s1);
        check({tag, "_valid"}, int'(result_valid), 1);
        check({tag, "_class0"}, int'(class_0), c0);
        check({tag, "_score0"}, int'($signed(score_0)), s0);
        check({tag, "_class1"}, int'(class_1), c1);
        check({tag, "_score1"}, int'($signed(score_1)), s1);
    endtask

    task automatic accept(input string tag);
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(result_valid), 0);
        check({tag, "_busy_drop"}, int'(busy), 0);
    endtask

    initial begin
        vec_t t1_s0, t1_s1, t2_s0, t2_s1;
        int   vcount;
        t1_s0 = '{8'sd3, -8'sd5, 8'sd7, 8'sd7, 8'sd1, 8'sd0, -8'sd128, 8'sd2, 8'sd6, 8'sd127};
        t1_s1 = '{8'sd10, 8'sd20, 8'sd30, 8'sd40, 8'sd50, 8'sd60, 8'sd70, 8'sd80, 8'sd90, -8'sd1};
        t2_s0 = '{8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5, 8'sd5};
        t2_s1 = '{-8'sd3, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1, -8'sd1};

        srstn = 1'b0; conv_start = 1'b0; fc2_done = 1'b0; result_ready = 1'b0;
        sram_write_enable_f = 1'b1; sram_bytemask_f = 4'hF; sram_waddr_f = '0;
        sram_wdata_f = '0; sram_wdata_f_1 = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_class0", int'(class_0), 0);
        check("rst_score0", int'(score_0), 0);
        tick();
        srstn = 1'b1;
        tick();

        // 1) basic argmax with extremes
        load_sets(t1_s0, t1_s1);
        run_scan("t1");
        check_result("t1", 9, 127, 8, 90);
        accept("t1");

        // 2) ties keep the lower index; ready high early completes on first valid cycle
        clear_scores();
        load_sets(t2_s0, t2_s1);
        result_ready = 1'b1;
        run_scan("t2");
        check_result("t2", 0, 5, 1, -1);
        tick();
        result_ready = 1'b0;
        check("t2_early_ready_drop", int'(result_valid), 0);

        // 3) full-mask word write plus out-of-range indices
        clear_scores();
        write_word(2'd0, 4'b0000, 8'h80, 8'h01);
        write_word(2'd2, 4'b0011, 8'h7F, 8'h7F);
        run_scan("t3");
        check_result("t3", 0, -128, 0, 1);

        // 4) hold VALID for 20 cycles while writes and fc2_done toggle
        for (int i = 0; i < 20; i++) begin
            sram_write_enable_f = i[0];
            sram_waddr_f        = 2'd0;
            sram_bytemask_f     = 4'b0000;
            sram_wdata_f        = 8'h7F;
            sram_wdata_f_1      = 8'h7F;
            fc2_done            = i[1];
            tick();
            check("t4_hold_valid", int'(result_valid), 1);
            check("t4_hold_score1", int'($signed(score_1)), 1);
        end
        sram_write_enable_f = 1'b1; sram_bytemask_f = 4'hF; fc2_done = 1'b0;
        tick();
        check_result("t4_held", 0, -128, 0, 1);
        accept("t4");
        run_scan("t4_rescan");
        check_result("t4_rescan", 0, -128, 0, 1);
        accept("t4_rescan");

        // 5) conv_start aborts a scan in its fourth cycle
        load_sets(t1_s0, t1_s1);
        fc2_done = 1'b1;
        tick();
        fc2_done = 1'b0;
        tick(); tick(); tick();
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        check("t5_busy_abort", int'(busy), 0);
        check("t5_valid_abort", int'(result_valid), 0);
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (result_valid) vcount++;
        end
        check("t5_no_valid", vcount, 0);
        load_sets(t1_s0, t1_s1);
        conv_start = 1'b1;
        fc2_done   = 1'b1;
        tick();
        conv_start = 1'b0;
        tick();
        check("t5_clear_wins", int'(busy), 0);
        fc2_done = 1'b0;
        tick();
        run_scan("t5_rescan");
        check_result("t5_rescan", 0, -128, 0, -128);
        accept("t5");

        // 6) asynchronous reset mid-VALID
        load_sets(t1_s0, t1_s1);
        run_scan("t6");
        check_result("t6", 9, 127, 8, 90);
        #2 srstn = 1'b0;
        #1;
        check("t6_async_valid", int'(result_valid), 0);
        check("t6_async_busy", int'(busy), 0);
        check("t6_async_class0", int'(class_0), 0);
        check("t6_async_score0", int'(score_0), 0);
        check("t6_async_class1", int'(class_1), 0);
        check("t6_async_score1", int'(score_1), 0);
        tick();
        srstn = 1'b1;
        tick();
        run_scan("t6_post");
        check_result("t6_post", 0, -128, 0, -128);
        accept("t6_post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
